// File: rtl/md_demux_pkg.sv
// ---------------------------------------------------------------------------
// md_demux_pkg
// Shared definitions for the particle-record demux tree:
//   PARTICLE_W  - width of one particle record (x,y,z as 3 x 32 bit)
//   MAX_SEL_W   - select width needed for the largest supported fan-out (256)
//   md_clog2()  - ceil(log2(v)), used for select-width and pointer sizing
//   md_entry_t  - one input FIFO entry {bcast, sel, data} at full size
// ---------------------------------------------------------------------------
package md_demux_pkg;

    localparam int unsigned PARTICLE_W = 3 * 32;
    localparam int unsigned MAX_SEL_W  = 8;

    function automatic int unsigned md_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic                  bcast;
        logic [MAX_SEL_W-1:0]  sel;
        logic [PARTICLE_W-1:0] data;
    } md_entry_t;

endpackage

// File: rtl/demux_in_fifo.sv
// ---------------------------------------------------------------------------
// demux_in_fifo
// Circular-buffer input FIFO for the demux tree. Pointers are log2(DEPTH)
// bits and wrap naturally; the occupancy count is one bit wider. Full and
// empty are registered from the next-state count so that downstream ready
// has no combinational path from the pop side.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push_i     - write request (ignored when full)
//   wdata_i    - entry to write
//   pop_i      - read request (ignored when empty)
//   rdata_o    - current head entry (valid when !empty_o)
//   full_o     - registered full flag
//   empty_o    - registered empty flag
// ---------------------------------------------------------------------------
module demux_in_fifo
    import md_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = md_clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/demux_tree_hs.sv
// ---------------------------------------------------------------------------
// demux_tree_hs
// 1-to-N demultiplexer with valid/ready handshake on every port. Entries are
// queued in an input FIFO and dispatched strictly in order into per-port
// one-entry holding registers. Broadcast entries wait until every port is
// free and then load all ports at once. Out-of-range unicast selects are
// discarded with a one-cycle drop_pulse and a saturating drop counter.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   in_data     - payload
//   in_sel      - target port index (ignored for broadcast)
//   in_bcast    - deliver to all ports
//   in_valid    - input request
//   in_ready    - FIFO can accept (registered)
//   out_data    - port p payload at [p*DATA_WIDTH +: DATA_WIDTH]
//   out_valid   - per-port holding register full
//   out_ready   - per-port consumer accept
//   drop_pulse  - one-cycle pulse per discarded out-of-range entry
//   drop_cnt    - saturating count of discarded entries
// ---------------------------------------------------------------------------
module demux_tree_hs
    import md_demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = PARTICLE_W,
    parameter int unsigned NUM_OUTPUT_PORTS = 128,
    parameter int unsigned SEL_WIDTH        = 7,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned DROP_CNT_WIDTH   = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic [SEL_WIDTH-1:0]                   in_sel,
    input  logic                                   in_bcast,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [NUM_OUTPUT_PORTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUTPUT_PORTS-1:0]            out_valid,
    input  logic [NUM_OUTPUT_PORTS-1:0]            out_ready,
    output logic                                   drop_pulse,
    output logic [DROP_CNT_WIDTH-1:0]              drop_cnt
);

    localparam int unsigned NP = NUM_OUTPUT_PORTS;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned EW = 1 + SEL_WIDTH + DATA_WIDTH;
    localparam logic [SEL_WIDTH:0] NUM_PORTS_L = (SEL_WIDTH+1)'(NUM_OUTPUT_PORTS);

    if (md_clog2(NUM_OUTPUT_PORTS) > SEL_WIDTH) begin : g_sel_width_chk
        $error("demux_tree_hs: SEL_WIDTH too small for NUM_OUTPUT_PORTS");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("demux_tree_hs: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [EW-1:0]             head;
    logic                      head_bcast;
    logic [SEL_WIDTH-1:0]      head_sel;
    logic [DW-1:0]             head_data;
    logic                      fifo_full;
    logic                      fifo_empty;

    logic [NP-1:0]             valid_q;
    logic [NP-1:0]             valid_d;
    logic [NP*DW-1:0]          data_q;
    logic [NP*DW-1:0]          data_d;
    logic                      drop_pulse_q;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_d;

    logic [NP-1:0]             port_free;
    logic [NP-1:0]             tgt;
    logic [NP-1:0]             load;
    logic                      sel_oor;
    logic                      do_pop;
    logic                      do_drop;

    demux_in_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .wdata_i ({in_bcast, in_sel, in_data}),
        .pop_i   (do_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_bcast, head_sel, head_data} = head;
    assign in_ready = ~fifo_full;

    always_comb begin
        // A draining port counts as free, so drain and reload can share a cycle.
        port_free = ~valid_q | out_ready;
        sel_oor   = ({1'b0, head_sel} >= NUM_PORTS_L);

        // One-hot decode by comparison avoids indexing past the port range.
        tgt = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            tgt[p] = (head_sel == SEL_WIDTH'(p));
        end

        do_pop  = 1'b0;
        do_drop = 1'b0;
        load    = '0;
        if (!fifo_empty) begin
            if (head_bcast) begin
                if (&port_free) begin
                    do_pop = 1'b1;
                    load   = '1;
                end
            end else if (sel_oor) begin
                do_pop  = 1'b1;
                do_drop = 1'b1;
            end else if (|(tgt & port_free)) begin
                do_pop = 1'b1;
                load   = tgt;
            end
        end

        valid_d = (valid_q & ~out_ready) | load;

        data_d = data_q;
        for (int unsigned p = 0; p < NP; p++) begin
            if (load[p]) begin
                data_d[p*DW +: DW] = head_data;
            end
        end

        drop_cnt_d = drop_cnt_q;
        if (do_drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            data_q       <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            drop_pulse_q <= do_drop;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_demux_tree_hs.sv
module tb_demux_tree_hs;
    import md_demux_pkg::*;

    localparam int DW  = 96;
    localparam int NP  = 100;
    localparam int SW  = 7;
    localparam int FD  = 4;
    localparam int DCW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     in_data = '0;
    logic [SW-1:0]     in_sel = '0;
    logic              in_bcast = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NP*DW-1:0]  out_data;
    logic [NP-1:0]     out_valid;
    logic [NP-1:0]     out_ready = '1;
    logic              drop_pulse;
    logic [DCW-1:0]    drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-port ordered delivery queues plus pending drops.
    logic [DW-1:0] exp_q [NP][$];
    int            drop_pending = 0;
    int            drops_seen   = 0;
    logic [NP-1:0] prev_hold = '0;
    logic [DW-1:0] prev_data [NP];
    bit            rnd_en = 1'b0;

    demux_tree_hs #(
        .DATA_WIDTH       (DW),
        .NUM_OUTPUT_PORTS (NP),
        .SEL_WIDTH        (SW),
        .FIFO_DEPTH       (FD),
        .DROP_CNT_WIDTH   (DCW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic bit model_empty();
        for (int p = 0; p < NP; p++) begin
            if (exp_q[p].size() != 0) return 1'b0;
        end
        return (drop_pending == 0);
    endfunction

    task automatic model_clear();
        for (int p = 0; p < NP; p++) exp_q[p].delete();
        drop_pending = 0;
    endtask

    task automatic model_push(input md_entry_t e);
        if (e.bcast) begin
            for (int p = 0; p < NP; p++) exp_q[p].push_back(e.data);
        end else if (int'(e.sel) < NP) begin
            exp_q[e.sel].push_back(e.data);
        end else begin
            drop_pending++;
        end
    endtask

    // Holds in_valid until the entry is accepted; returns #1 after the accept edge.
    task automatic send(input logic b, input int unsigned s, input logic [DW-1:0] d);
        md_entry_t   e;
        int unsigned guard;
        logic        acc;
        e.bcast = b;
        e.sel   = 8'(s);
        e.data  = d;
        guard   = 0;
        acc     = 1'b0;
        in_valid = 1'b1;
        in_bcast = e.bcast;
        in_sel   = e.sel[SW-1:0];
        in_data  = e.data;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            guard++;
        end
        #1;
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=blocked exp=accepted sel=%0d", s);
        end else begin
            model_push(e);
        end
    endtask

    task automatic wait_drain(input string nm);
        int unsigned guard;
        guard = 0;
        while (!model_empty() && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk(nm, 128'(model_empty()), 128'(1));
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        #2;
        if (rnd_en) begin
            for (int p = 0; p < NP; p++) out_ready[p] = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every handshake pops the port's expected queue; held data must be stable.
    always @(negedge clk) begin
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        int            ec;
        if (rst) begin
            prev_hold  = '0;
            drops_seen = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                d = out_data[p*DW +: DW];
                if (prev_hold[p]) begin
                    checks++;
                    if (!out_valid[p] || d !== prev_data[p]) begin
                        failures++;
                        $display("FAIL hold_stable port=%0d got_v=%0b got=%0h exp=%0h",
                                 p, out_valid[p], d, prev_data[p]);
                    end
                end
                if (out_valid[p] && out_ready[p]) begin
                    checks++;
                    if (exp_q[p].size() == 0) begin
                        failures++;
                        $display("FAIL spurious_delivery port=%0d got=%0h exp=none", p, d);
                    end else begin
                        e = exp_q[p].pop_front();
                        if (d !== e) begin
                            failures++;
                            $display("FAIL delivery_data port=%0d got=%0h exp=%0h", p, d, e);
                        end
                    end
                end
                prev_hold[p] = out_valid[p] & ~out_ready[p];
                prev_data[p] = d;
            end
            if (drop_pulse) begin
                drops_seen++;
                checks++;
                if (drop_pending == 0) begin
                    failures++;
                    $display("FAIL drop_unexpected got=pulse exp=none");
                end else begin
                    drop_pending--;
                end
                ec = (drops_seen > 15) ? 15 : drops_seen;
                chk("drop_cnt_track", 128'(drop_cnt), 128'(ec));
            end
        end
    end

    initial begin
        logic [NP*DW-1:0] tmp;
        logic [DW-1:0]    bd;
        int               bad;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data_ones", 128'($countones(out_data)), 128'(0));
        chk("rst_drop_pulse", 128'(drop_pulse), 128'(0));
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));

        // Single unicast latency and isolation
        send(1'b0, 5, {12{8'hA5}});
        @(negedge clk);
        chk("lat_not_early", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        chk("lat_visible", 128'(out_valid), 128'(onehot(5)));
        chk("lat_slice5", 128'(out_data[5*DW +: DW]), 128'({12{8'hA5}}));
        tmp = out_data;
        tmp[5*DW +: DW] = '0;
        chk("lat_other_zero", 128'($countones(tmp)), 128'(0));
        @(posedge clk); #1;
        chk("lat_one_cycle", 128'(out_valid), 128'(0));

        // Fill behind a stalled port
        out_ready[3] = 1'b0;
        for (int k = 0; k < 5; k++) send(1'b0, 3, rnd_data());
        @(negedge clk);
        chk("fill_in_ready_low", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        out_ready[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_port3_valid", 128'(out_valid[3]), 128'(1));
            if (i == 0) chk("drain_ready_still_low", 128'(in_ready), 128'(0));
            if (i == 1) chk("drain_ready_rises", 128'(in_ready), 128'(1));
        end
        @(negedge clk);
        chk("drain_port3_done", 128'(out_valid[3]), 128'(0));
        @(posedge clk); #1;

        // Out-of-range select is dropped, next entry flows normally
        send(1'b0, 120, rnd_data());
        @(posedge clk); #1;
        chk("drop_pulse_hi", 128'(drop_pulse), 128'(1));
        chk("drop_cnt_one", 128'(drop_cnt), 128'(1));
        chk("drop_no_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        chk("drop_pulse_once", 128'(drop_pulse), 128'(0));
        send(1'b0, 0, rnd_data());
        @(posedge clk); #1;
        chk("after_drop_sel0", 128'(out_valid), 128'(onehot(0)));
        @(posedge clk); #1;

        // Broadcast stalls behind an undrained port
        out_ready[7] = 1'b0;
        send(1'b0, 7, rnd_data());
        repeat (2) @(posedge clk);
        #1;
        bd = rnd_data();
        send(1'b1, $urandom_range(0, 127), bd);
        repeat (5) @(posedge clk);
        #1;
        chk("bcast_stalled", 128'(out_valid), 128'(onehot(7)));
        out_ready[7] = 1'b1;
        @(posedge clk); #1;
        chk("bcast_all_valid", 128'(out_valid), 128'({NP{1'b1}}));
        bad = 0;
        for (int p = 0; p < NP; p++) if (out_data[p*DW +: DW] !== bd) bad++;
        chk("bcast_payload_mismatch_ports", 128'(bad), 128'(0));
        wait_drain("bcast_drain");
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back unicasts, one delivery per cycle
        fork
            begin
                for (int i = 0; i < 10; i++) send(1'b0, i, rnd_data());
            end
            begin
                for (int j = 0; j < 12; j++) begin
                    @(negedge clk);
                    if (j < 10) chk("b2b_in_ready", 128'(in_ready), 128'(1));
                    if (j >= 2) chk("b2b_onehot", 128'(out_valid), 128'(onehot(j - 2)));
                end
            end
        join
        wait_drain("b2b_drain");

        // Randomized traffic with random back-pressure
        rnd_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 5)       send(1'b1, $urandom_range(0, 127), rnd_data());
            else if (r < 15) send(1'b0, $urandom_range(NP, 127), rnd_data());
            else             send(1'b0, $urandom_range(0, NP - 1), rnd_data());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        rnd_en = 1'b0;
        out_ready = '1;
        wait_drain("random_drain");

        // Reset with a full FIFO and three held ports
        out_ready = '0;
        send(1'b0, 10, rnd_data());
        send(1'b0, 11, rnd_data());
        send(1'b0, 12, rnd_data());
        for (int k = 0; k < 4; k++) send(1'b0, 10, rnd_data());
        @(negedge clk);
        chk("prerst_full", 128'(in_ready), 128'(0));
        chk("prerst_valid", 128'(out_valid), 128'(onehot(10) | onehot(11) | onehot(12)));
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_drop_cnt", 128'(drop_cnt), 128'(0));
        chk("midrst_data_ones", 128'($countones(out_data)), 128'(0));
        out_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_no_delivery", 128'(out_valid), 128'(0));

        // Drop counter saturation
        for (int k = 0; k < 17; k++) send(1'b0, $urandom_range(NP, 127), rnd_data());
        repeat (3) @(posedge clk);
        #1;
        chk("drop_cnt_saturated", 128'(drop_cnt), 128'(15));
        wait_drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
